// File: rtl/ysyx_24080014_mem_arbiter.sv
// ysyx_24080014_mem_arbiter: shares the single memory access unit between IFU (reads) and
// LSU (reads/writes). One transaction at a time: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
// Optional feature: define ARB_RR_EN for round-robin arbitration; otherwise LSU has fixed priority.
module ysyx_24080014_mem_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  // IFU side
  input  logic              ifu_req_valid_i,
  output logic              ifu_req_ready_o,
  input  logic [ADDR_W-1:0] ifu_raddr_i,
  output logic              ifu_rsp_valid_o,
  output logic [DATA_W-1:0] ifu_rdata_o,
  // LSU side
  input  logic              lsu_req_valid_i,
  output logic              lsu_req_ready_o,
  input  logic              lsu_wen_i,
  input  logic [ADDR_W-1:0] lsu_addr_i,
  input  logic [DATA_W-1:0] lsu_wdata_i,
  input  logic [7:0]        lsu_wmask_i,
  output logic              lsu_rsp_valid_o,
  output logic [DATA_W-1:0] lsu_rdata_o,
  // memory unit side
  output logic              mem_ren_o,
  output logic              mem_wen_o,
  output logic [ADDR_W-1:0] mem_raddr_o,
  output logic [ADDR_W-1:0] mem_waddr_o,
  output logic [DATA_W-1:0] mem_din_o,
  output logic [7:0]        mem_wmask_o,
  input  logic [DATA_W-1:0] mem_dout_i,
  input  logic              mem_ready_i,
  output logic              rsp_err_o
);

  localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              owner_q, owner_d;      // 1 = LSU owns the transaction
  logic              wen_q, wen_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [7:0]        wmask_q, wmask_d;
  logic              mem_ren_q, mem_ren_d;
  logic              mem_wen_q, mem_wen_d;
  logic              ifu_rsp_valid_q, ifu_rsp_valid_d;
  logic              lsu_rsp_valid_q, lsu_rsp_valid_d;
  logic [DATA_W-1:0] ifu_rdata_q, ifu_rdata_d;
  logic [DATA_W-1:0] lsu_rdata_q, lsu_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  logic              idle_c;
  logic              lsu_win_c;
  logic              ifu_win_c;
  logic              rsp_fire_c;
  logic [DATA_W-1:0] rsp_data_c;
  logic              rsp_err_c;

`ifdef ARB_RR_EN
  logic              last_grant_q, last_grant_d;  // 1 = LSU granted last

  // Round-robin winner: on a tie, grant the requester not granted last time.
  always_comb begin
    lsu_win_c = lsu_req_valid_i && (!ifu_req_valid_i || !last_grant_q);
  end
`else
  // Fixed priority winner: LSU always wins a tie.
  always_comb begin
    lsu_win_c = lsu_req_valid_i;
  end
`endif

  // Request handshake: ready only in IDLE, only toward the winner.
  always_comb begin
    idle_c          = (state_q == S_IDLE) && rst_n_i;
    ifu_win_c       = ifu_req_valid_i && !lsu_win_c;
    ifu_req_ready_o = idle_c && ifu_win_c;
    lsu_req_ready_o = idle_c && lsu_win_c;
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    owner_d         = owner_q;
    wen_d           = wen_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    wmask_d         = wmask_q;
    mem_ren_d       = 1'b0;
    mem_wen_d       = 1'b0;
    ifu_rsp_valid_d = 1'b0;
    lsu_rsp_valid_d = 1'b0;
    ifu_rdata_d     = ifu_rdata_q;
    lsu_rdata_d     = lsu_rdata_q;
    rsp_err_d       = rsp_err_q;
    rsp_fire_c      = 1'b0;
    rsp_data_c      = '0;
    rsp_err_c       = 1'b0;
`ifdef ARB_RR_EN
    last_grant_d    = last_grant_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (ifu_win_c || lsu_win_c) begin
          owner_d   = lsu_win_c;
          wen_d     = lsu_win_c && lsu_wen_i;
          addr_d    = lsu_win_c ? lsu_addr_i : ifu_raddr_i;
          wdata_d   = lsu_win_c ? lsu_wdata_i : '0;
          wmask_d   = lsu_win_c ? lsu_wmask_i : 8'h00;
          mem_ren_d = !(lsu_win_c && lsu_wen_i);
          mem_wen_d = lsu_win_c && lsu_wen_i;
          cnt_d     = '0;
          state_d   = S_ISSUE;
`ifdef ARB_RR_EN
          last_grant_d = lsu_win_c;
`endif
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem_ready_i) begin
          rsp_fire_c = 1'b1;
          rsp_data_c = wen_q ? '0 : mem_dout_i;
          rsp_err_c  = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          rsp_fire_c = 1'b1;
          rsp_data_c = '0;
          rsp_err_c  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (rsp_fire_c) begin
          cnt_d           = '0;
          ifu_rsp_valid_d = !owner_q;
          lsu_rsp_valid_d = owner_q;
          rsp_err_d       = rsp_err_c;
          if (owner_q) begin
            lsu_rdata_d = rsp_data_c;
          end else begin
            ifu_rdata_d = rsp_data_c;
          end
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q         <= S_IDLE;
      cnt_q           <= '0;
      owner_q         <= 1'b0;
      wen_q           <= 1'b0;
      addr_q          <= '0;
      wdata_q         <= '0;
      wmask_q         <= 8'h00;
      mem_ren_q       <= 1'b0;
      mem_wen_q       <= 1'b0;
      ifu_rsp_valid_q <= 1'b0;
      lsu_rsp_valid_q <= 1'b0;
      ifu_rdata_q     <= '0;
      lsu_rdata_q     <= '0;
      rsp_err_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      owner_q         <= owner_d;
      wen_q           <= wen_d;
      addr_q          <= addr_d;
      wdata_q         <= wdata_d;
      wmask_q         <= wmask_d;
      mem_ren_q       <= mem_ren_d;
      mem_wen_q       <= mem_wen_d;
      ifu_rsp_valid_q <= ifu_rsp_valid_d;
      lsu_rsp_valid_q <= lsu_rsp_valid_d;
      ifu_rdata_q     <= ifu_rdata_d;
      lsu_rdata_q     <= lsu_rdata_d;
      rsp_err_q       <= rsp_err_d;
    end
  end

`ifdef ARB_RR_EN
  // Round-robin history, reset to IFU.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      last_grant_q <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`endif

  assign mem_ren_o       = mem_ren_q;
  assign mem_wen_o       = mem_wen_q;
  assign mem_raddr_o     = addr_q;
  assign mem_waddr_o     = addr_q;
  assign mem_din_o       = wdata_q;
  assign mem_wmask_o     = wmask_q;
  assign ifu_rsp_valid_o = ifu_rsp_valid_q;
  assign lsu_rsp_valid_o = lsu_rsp_valid_q;
  assign ifu_rdata_o     = ifu_rdata_q;
  assign lsu_rdata_o     = lsu_rdata_q;
  assign rsp_err_o       = rsp_err_q;

endmodule

// File: tb/tb_ysyx_24080014_mem_arbiter.sv
// Testbench for ysyx_24080014_mem_arbiter: vector table of single transactions plus
// directed sequences for arbitration, reset mid-transaction and busy-time payload changes.
module tb_ysyx_24080014_mem_arbiter;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned TIMEOUT = 16;

  logic              clk;
  logic              rst_n;
  logic              ifu_req_valid, ifu_req_ready, ifu_rsp_valid;
  logic [ADDR_W-1:0] ifu_raddr;
  logic [DATA_W-1:0] ifu_rdata;
  logic              lsu_req_valid, lsu_req_ready, lsu_wen, lsu_rsp_valid;
  logic [ADDR_W-1:0] lsu_addr;
  logic [DATA_W-1:0] lsu_wdata, lsu_rdata;
  logic [7:0]        lsu_wmask;
  logic              mem_ren, mem_wen, mem_ready, rsp_err;
  logic [ADDR_W-1:0] mem_raddr, mem_waddr;
  logic [DATA_W-1:0] mem_din, mem_dout;
  logic [7:0]        mem_wmask;

  int checks = 0;
  int errors = 0;

  ysyx_24080014_mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .ifu_req_valid_i(ifu_req_valid), .ifu_req_ready_o(ifu_req_ready),
    .ifu_raddr_i(ifu_raddr), .ifu_rsp_valid_o(ifu_rsp_valid), .ifu_rdata_o(ifu_rdata),
    .lsu_req_valid_i(lsu_req_valid), .lsu_req_ready_o(lsu_req_ready),
    .lsu_wen_i(lsu_wen), .lsu_addr_i(lsu_addr), .lsu_wdata_i(lsu_wdata),
    .lsu_wmask_i(lsu_wmask), .lsu_rsp_valid_o(lsu_rsp_valid), .lsu_rdata_o(lsu_rdata),
    .mem_ren_o(mem_ren), .mem_wen_o(mem_wen), .mem_raddr_o(mem_raddr),
    .mem_waddr_o(mem_waddr), .mem_din_o(mem_din), .mem_wmask_o(mem_wmask),
    .mem_dout_i(mem_dout), .mem_ready_i(mem_ready), .rsp_err_o(rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        is_lsu;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [7:0]  wmask;
    int          lat;        // cycles from strobe to mem_ready; 0 = never
    logic        early;      // spurious mem_ready during the strobe cycle
    logic [31:0] dout;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    ifu_req_valid = 1'b0; ifu_raddr = '0;
    lsu_req_valid = 1'b0; lsu_wen = 1'b0; lsu_addr = '0; lsu_wdata = '0; lsu_wmask = '0;
    mem_ready = 1'b0; mem_dout = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // One full transaction starting in an IDLE cycle; ends in the IDLE cycle after RESP.
  task automatic run_vec(input vec_t v);
    int          seen_lat;
    int          exp_lat;
    logic        own_rsp, oth_rsp;
    logic [31:0] own_rdata;
    seen_lat = 0;
    exp_lat  = (v.lat == 0) ? int'(TIMEOUT) + 1 : v.lat + 1;
    if (v.is_lsu) begin
      lsu_req_valid = 1'b1; lsu_wen = v.wen; lsu_addr = v.addr;
      lsu_wdata = v.wdata; lsu_wmask = v.wmask;
    end else begin
      ifu_req_valid = 1'b1; ifu_raddr = v.addr;
    end
    #1;
    chk("req_ready", v.is_lsu ? 32'(lsu_req_ready) : 32'(ifu_req_ready), 32'd1);
    tick();
    idle_inputs();
    lsu_addr = 32'hFFFF_FFFF; ifu_raddr = 32'hFFFF_FFFF; lsu_wdata = 32'hFFFF_FFFF;
    chk("mem_ren", 32'(mem_ren), 32'(!v.wen));
    chk("mem_wen", 32'(mem_wen), 32'(v.wen));
    if (v.wen) begin
      chk("mem_waddr", mem_waddr, v.addr);
      chk("mem_din", mem_din, v.wdata);
      chk("mem_wmask", 32'(mem_wmask), 32'(v.wmask));
    end else begin
      chk("mem_raddr", mem_raddr, v.addr);
    end
    if (v.early) begin
      mem_ready = 1'b1; mem_dout = 32'hBAD0_BAD0;
    end
    for (int c = 1; c <= 40; c++) begin
      tick();
      mem_ready = 1'b0;
      if ((v.is_lsu ? lsu_rsp_valid : ifu_rsp_valid) === 1'b1) begin
        seen_lat = c;
        break;
      end
      if (c == v.lat) begin
        mem_ready = 1'b1; mem_dout = v.dout;
      end
    end
    chk("rsp_latency", 32'(seen_lat), 32'(exp_lat));
    oth_rsp   = v.is_lsu ? ifu_rsp_valid : lsu_rsp_valid;
    own_rdata = v.is_lsu ? lsu_rdata : ifu_rdata;
    chk("other_rsp_valid", 32'(oth_rsp), 32'd0);
    chk("rdata", own_rdata, v.exp_rdata);
    chk("rsp_err", 32'(rsp_err), 32'(v.exp_err));
    chk("strobes_in_resp", 32'({mem_ren, mem_wen}), 32'd0);
    tick();
    own_rsp   = v.is_lsu ? lsu_rsp_valid : ifu_rsp_valid;
    own_rdata = v.is_lsu ? lsu_rdata : ifu_rdata;
    chk("rsp_pulse_end", 32'(own_rsp), 32'd0);
    chk("rdata_hold", own_rdata, v.exp_rdata);
    chk("err_hold", 32'(rsp_err), 32'(v.exp_err));
  endtask

  initial begin
    logic exp_lsu[3];
    vec_t v;

    vecs[0] = '{1'b0, 1'b0, 32'h8000_0000, 32'h0, 8'h00, 2,  1'b0, 32'h0000_0413, 32'h0000_0413, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 32'h8000_1000, 32'hDEAD_BEEF, 8'h0F, 1, 1'b0, 32'h1234_5678, 32'h0, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 32'h8000_2000, 32'h0, 8'h00, 3,  1'b0, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 32'h8000_0004, 32'h0, 8'h00, 0,  1'b0, 32'h0, 32'h0, 1'b1};
    vecs[4] = '{1'b0, 1'b0, 32'h8000_0008, 32'h0, 8'h00, 1,  1'b0, 32'h0000_55AA, 32'h0000_55AA, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 32'h8000_3000, 32'h0, 8'h00, 16, 1'b1, 32'h0BAD_C0DE, 32'h0BAD_C0DE, 1'b0};

    idle_inputs();
    do_reset();
    chk("rst_ifu_rsp", 32'(ifu_rsp_valid), 32'd0);
    chk("rst_lsu_rsp", 32'(lsu_rsp_valid), 32'd0);
    chk("rst_strobes", 32'({mem_ren, mem_wen}), 32'd0);
    chk("rst_raddr", mem_raddr, 32'd0);
    chk("rst_err", 32'(rsp_err), 32'd0);
    tick();

    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i]);
    end

    // Reset during WAIT abandons the transaction; a late mem_ready is ignored.
    ifu_req_valid = 1'b1; ifu_raddr = 32'h8000_0040;
    tick();
    ifu_req_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; mem_ready = 1'b1; mem_dout = 32'h0000_0077;
    tick();
    mem_ready = 1'b0;
    chk("rstw_ifu_rsp", 32'(ifu_rsp_valid), 32'd0);
    chk("rstw_lsu_rsp", 32'(lsu_rsp_valid), 32'd0);
    chk("rstw_strobes", 32'({mem_ren, mem_wen}), 32'd0);
    chk("rstw_ifu_rdata", ifu_rdata, 32'd0);
    chk("rstw_err", 32'(rsp_err), 32'd0);
    chk("rstw_raddr", mem_raddr, 32'd0);
    tick();
    chk("rstw_ifu_rsp2", 32'(ifu_rsp_valid), 32'd0);
    v = '{1'b0, 1'b0, 32'h8000_0044, 32'h0, 8'h00, 2, 1'b0, 32'h0000_0099, 32'h0000_0099, 1'b0};
    run_vec(v);

    // Both requesters held valid for three transactions.
`ifdef ARB_RR_EN
    exp_lsu[0] = 1'b1; exp_lsu[1] = 1'b0; exp_lsu[2] = 1'b1;
`else
    exp_lsu[0] = 1'b1; exp_lsu[1] = 1'b1; exp_lsu[2] = 1'b1;
`endif
    do_reset();
    tick();
    ifu_req_valid = 1'b1; ifu_raddr = 32'h0000_0100;
    lsu_req_valid = 1'b1; lsu_wen = 1'b0; lsu_addr = 32'h0000_0200;
    for (int n = 0; n < 3; n++) begin
      #1;
      chk("arb_lsu_ready", 32'(lsu_req_ready), 32'(exp_lsu[n]));
      chk("arb_ifu_ready", 32'(ifu_req_ready), 32'(!exp_lsu[n]));
      tick();
      chk("arb_raddr", mem_raddr, exp_lsu[n] ? 32'h0000_0200 : 32'h0000_0100);
      chk("arb_busy_ready", 32'({ifu_req_ready, lsu_req_ready}), 32'd0);
      tick();
      mem_ready = 1'b1; mem_dout = 32'(n + 1);
      tick();
      mem_ready = 1'b0;
      chk("arb_lsu_rsp", 32'(lsu_rsp_valid), 32'(exp_lsu[n]));
      chk("arb_ifu_rsp", 32'(ifu_rsp_valid), 32'(!exp_lsu[n]));
      tick();
    end
    idle_inputs();
    tick();

    // IFU payload changes while LSU owns the memory; the value at accept is used.
    lsu_req_valid = 1'b1; lsu_wen = 1'b1; lsu_addr = 32'h8000_2000;
    lsu_wdata = 32'h0000_0001; lsu_wmask = 8'hFF;
    tick();
    lsu_req_valid = 1'b0;
    ifu_req_valid = 1'b1; ifu_raddr = 32'h0000_1111;
    #1;
    chk("busy_ready_issue", 32'(ifu_req_ready), 32'd0);
    tick();
    ifu_raddr = 32'h0000_2222; mem_ready = 1'b1;
    #1;
    chk("busy_ready_wait", 32'(ifu_req_ready), 32'd0);
    tick();
    mem_ready = 1'b0; ifu_raddr = 32'h0000_3333;
    #1;
    chk("busy_ready_resp", 32'(ifu_req_ready), 32'd0);
    chk("busy_lsu_rsp", 32'(lsu_rsp_valid), 32'd1);
    tick();
    ifu_raddr = 32'h8000_0ABC;
    #1;
    chk("busy_ready_idle", 32'(ifu_req_ready), 32'd1);
    tick();
    ifu_req_valid = 1'b0; ifu_raddr = 32'h0000_DEAD;
    chk("busy_raddr", mem_raddr, 32'h8000_0ABC);
    chk("busy_ren", 32'(mem_ren), 32'd1);
    tick();
    mem_ready = 1'b1; mem_dout = 32'h0000_0042;
    tick();
    mem_ready = 1'b0;
    chk("busy_ifu_rsp", 32'(ifu_rsp_valid), 32'd1);
    chk("busy_ifu_rdata", ifu_rdata, 32'h0000_0042);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
